slatch_arb: RTL and testbench

SLATCH_ARB -- requirements
Module: slatch_arb

---
 rtl/slatch_arb.sv | 84 ++++++++
 tb/tb_slatch_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/slatch_arb.sv
// slatch_arb: arbitrated shared latch.
//   N requesting channels compete to write a single W-bit register q.
//   At most one eligible channel (req high, ack low) is granted per clock
//   edge; the grant loads q, raises that channel's ack, records the
//   channel index in src and pulses upd for one cycle.  ack[i] is held
//   while req[i] stays high and cleared as soon as req[i] drops, so a
//   channel must release req before it can write again.
//   RR=0 selects fixed priority (channel 0 highest), RR=1 round-robin
//   starting after the most recent grantee.
//
// Ports:
//   clk    rising-edge clock
//   res_n  asynchronous active-low reset
//   req    [N-1:0]    per-channel write request
//   d      [N*W-1:0]  per-channel write data, channel i at [i*W +: W]
//   ack    [N-1:0]    per-channel acknowledge (registered)
//   q      [W-1:0]    latched value (registered)
//   upd    1-cycle pulse following any edge that wrote q
//   src    [SW-1:0]   index of the most recent writer (registered)
module slatch_arb #(
  parameter int unsigned    N    = 3,
  parameter int unsigned    W    = 1,
  parameter int unsigned    RR   = 0,
  parameter logic [W-1:0]   INIT = '0,
  localparam int unsigned   SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   d,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     q,
  output logic             upd,
  output logic [SW-1:0]    src
);

  logic [N-1:0]  elig;
  logic [N-1:0]  gnt;
  logic          found;
  logic [SW-1:0] gidx;
  logic [SW-1:0] last;
  int unsigned   cand;

  // Search order starts at last+1 for round-robin, at 0 for fixed
  // priority; the first eligible channel in that order wins.
  always_comb begin
    elig  = req & ~ack;
    found = 1'b0;
    gidx  = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (RR != 0) begin
        cand = (32'(last) + 1 + k) % N;
      end else begin
        cand = k;
      end
      if (!found && elig[SW'(cand)]) begin
        found = 1'b1;
        gidx  = SW'(cand);
      end
    end
    gnt = found ? (N'(1) << gidx) : '0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q    <= INIT;
      ack  <= '0;
      upd  <= 1'b0;
      src  <= '0;
      last <= SW'(N - 1);
    end else begin
      // Dropped requests clear their ack; the grantee (ack was low) sets its own.
      ack <= (ack & req) | gnt;
      upd <= found;
      if (found) begin
        q    <= d[32'(gidx) * W +: W];
        src  <= gidx;
        last <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_slatch_arb.sv
module tb_slatch_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: N=3 W=8 fixed priority; B: N=3 W=8 round-robin; C: N=16 W=32 round-robin
  logic [2:0]   reqA, ackA, reqB, ackB;
  logic [23:0]  dA, dB;
  logic [7:0]   qA, qB;
  logic         updA, updB, updC;
  logic [1:0]   srcA, srcB;
  logic [15:0]  reqC, ackC;
  logic [511:0] dC;
  logic [31:0]  qC;
  logic [3:0]   srcC;

  slatch_arb #(.N(3), .W(8), .RR(0), .INIT(8'h5A)) dut_a (
    .clk(clk), .res_n(rst_n), .req(reqA), .d(dA),
    .ack(ackA), .q(qA), .upd(updA), .src(srcA));

  slatch_arb #(.N(3), .W(8), .RR(1), .INIT(8'h00)) dut_b (
    .clk(clk), .res_n(rst_n), .req(reqB), .d(dB),
    .ack(ackB), .q(qB), .upd(updB), .src(srcB));

  slatch_arb #(.N(16), .W(32), .RR(1), .INIT(32'hDEAD_BEEF)) dut_c (
    .clk(clk), .res_n(rst_n), .req(reqC), .d(dC),
    .ack(ackC), .q(qC), .upd(updC), .src(srcC));

  int vectors = 0;
  int fails   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one record per instance, advanced once per edge.
  typedef struct {
    logic [31:0] q;
    logic [15:0] ack;
    int          src;
    logic        upd;
    int          last;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t mreset(input logic [31:0] init, input int n);
    mstate_t s;
    s.q = init; s.ack = '0; s.src = 0; s.upd = 1'b0; s.last = n - 1;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int n, input int w,
                                   input int rr, input logic [15:0] rq,
                                   input logic [511:0] dv);
    mstate_t ns = s;
    int win = -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (rr != 0) ? (s.last + 1 + k) % n : k;
      if (win < 0 && rq[c] && !s.ack[c]) win = c;
    end
    ns.ack = s.ack & rq;
    ns.upd = 1'b0;
    if (win >= 0) begin
      ns.ack[win] = 1'b1;
      ns.q    = 32'((dv >> (win * w)) & ((64'd1 << w) - 64'd1));
      ns.src  = win;
      ns.upd  = 1'b1;
      ns.last = win;
    end
    return ns;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] = mreset(32'h5A, 3);
      m[1] = mreset(32'h00, 3);
      m[2] = mreset(32'hDEAD_BEEF, 16);
    end else begin
      m[0] = step(m[0], 3, 8, 0, 16'(reqA), 512'(dA));
      m[1] = step(m[1], 3, 8, 1, 16'(reqB), 512'(dB));
      m[2] = step(m[2], 16, 32, 1, reqC, dC);
    end
  end

  always @(negedge clk) begin
    cmp("A.q",   32'(qA),   m[0].q);
    cmp("A.ack", 32'(ackA), 32'(m[0].ack));
    cmp("A.upd", 32'(updA), 32'(m[0].upd));
    cmp("A.src", 32'(srcA), 32'(m[0].src));
    cmp("B.q",   32'(qB),   m[1].q);
    cmp("B.ack", 32'(ackB), 32'(m[1].ack));
    cmp("B.upd", 32'(updB), 32'(m[1].upd));
    cmp("B.src", 32'(srcB), 32'(m[1].src));
    cmp("C.q",   qC,        m[2].q);
    cmp("C.ack", 32'(ackC), 32'(m[2].ack));
    cmp("C.upd", 32'(updC), 32'(m[2].upd));
    cmp("C.src", 32'(srcC), 32'(m[2].src));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chkA(input string tag, input logic [7:0] eq, input logic [2:0] eack,
                      input logic eupd, input logic [1:0] esrc);
    cmp({tag, ".q"},   32'(qA),   32'(eq));
    cmp({tag, ".ack"}, 32'(ackA), 32'(eack));
    cmp({tag, ".upd"}, 32'(updA), 32'(eupd));
    cmp({tag, ".src"}, 32'(srcA), 32'(esrc));
  endtask

  int nB;
  int prevB;

  initial begin
    rst_n = 1'b0;
    reqA = '0; dA = '0; reqB = '0; dB = '0; reqC = '0; dC = '0;
    repeat (2) tick();
    chkA("rst", 8'h5A, 3'b000, 1'b0, 2'd0);
    cmp("rst.C.q", qC, 32'hDEAD_BEEF);

    rst_n = 1'b1;
    tick();
    chkA("idle", 8'h5A, 3'b000, 1'b0, 2'd0);

    // All three channels request together: fixed priority drains 0,1,2.
    reqA = 3'b111; dA = {8'h33, 8'h22, 8'h11};
    tick(); chkA("e1", 8'h11, 3'b001, 1'b1, 2'd0);
    tick(); chkA("e2", 8'h22, 3'b011, 1'b1, 2'd1);
    tick(); chkA("e3", 8'h33, 3'b111, 1'b1, 2'd2);
    tick(); chkA("e4", 8'h33, 3'b111, 1'b0, 2'd2);

    // Channel 1 drops for one cycle, then re-raises with new data.
    reqA = 3'b101;
    tick(); chkA("drop", 8'h33, 3'b101, 1'b0, 2'd2);
    reqA = 3'b111; dA[15:8] = 8'hC3;
    tick(); chkA("rer", 8'hC3, 3'b111, 1'b1, 2'd1);

    // Reach ack=010, q=22, then assert reset between edges.
    reqA = 3'b000;
    tick();
    reqA = 3'b010; dA[15:8] = 8'h22;
    tick(); chkA("pre", 8'h22, 3'b010, 1'b1, 2'd1);
    #2 rst_n = 1'b0;
    #1 chkA("async", 8'h5A, 3'b000, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    // req held through reset is granted on the first edge after release
    tick(); chkA("post", 8'h22, 3'b010, 1'b1, 2'd1);

    // Channel 2 loses a race, then withdraws before ever writing.
    reqA = 3'b000;
    tick();
    reqA = 3'b110; dA = {8'h66, 8'h55, 8'h00};
    tick(); chkA("race", 8'h55, 3'b010, 1'b1, 2'd1);
    reqA = 3'b010;
    tick(); chkA("wdraw", 8'h55, 3'b010, 1'b0, 2'd1);

    // Channels 0 and 2 toggle req every 2 cycles on both A and B.
    dA = {8'hA2, 8'h00, 8'hA0};
    dB = {8'hB2, 8'h00, 8'hB0};
    nB = 0;
    prevB = 2;
    for (int c = 0; c < 16; c++) begin
      reqA = (((c / 2) % 2) == 0) ? 3'b101 : 3'b000;
      reqB = reqA;
      tick();
      if (updB) begin
        cmp("B.alt", 32'(srcB), (prevB == 0) ? 32'd2 : 32'd0);
        prevB = int'(srcB);
        nB++;
      end
    end
    cmp("B.grants", 32'(nB), 32'd8);
    reqA = '0; reqB = '0;

    // Sixteen channels all requesting: round-robin grants 0..15 in order.
    for (int i = 0; i < 16; i++) dC[i*32 +: 32] = 32'hC000_0000 + 32'(i);
    reqC = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      cmp("C.seq.src", 32'(srcC), 32'(i));
      cmp("C.seq.upd", 32'(updC), 32'd1);
      cmp("C.seq.q",   qC, 32'hC000_0000 + 32'(i));
    end
    tick();
    cmp("C.end.upd", 32'(updC), 32'd0);
    cmp("C.end.ack", 32'(ackC), 32'h0000_FFFF);
    reqC = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
